ktms_debug_cnt_bank: RTL and testbench

Parametrised bank of `n` flop-based debug event counters, each `cwidth` bits wide, readable and writable over the AFU MMIO bus. It adds a per-bank control register with freeze, clear-all and clear-on-read, a selectable wrap or saturate mode, and a sticky overflow vector. It sits beside the functional pipelines, which drive `i_inc` strobes. It returns read data on the shared MMIO read-return path.

---
 rtl/ktms_debug_cnt_bank.sv | 146 ++++++++++++++
 tb/tb_ktms_debug_cnt_bank.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ktms_debug_cnt_bank.sv
// Bank of n MMIO-visible debug event counters with freeze, clear-all, clear-on-read and sticky overflow.
// Read data returns 2 cycles after the request is sampled; no backpressure, requests are never stalled.
module ktms_debug_cnt_bank #(
  parameter int          n             = 16,
  parameter int          cwidth        = 32,
  parameter bit          sat           = 1'b0,
  parameter logic [23:0] mmioaddr      = 24'h000000,
  parameter int          mmiobus_width = 92
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [0:mmiobus_width-1] i_mmiobus,
  input  logic [n-1:0]             i_inc,
  output logic                     o_mmio_rd_v,
  output logic [0:63]              o_mmio_rd_d
);

  localparam int                IW       = $clog2(n + 2);
  localparam logic [IW-1:0]     IDX_CTRL = IW'(n);
  localparam logic [IW-1:0]     IDX_OVF  = IW'(n + 1);
  localparam logic [cwidth-1:0] CMAX     = '1;

  logic        bus_vld, bus_cfg, bus_rnw, bus_dw;
  logic [23:0] bus_addr;
  logic [63:0] bus_dat;
  logic [24:0] addr_off;
  logic [22:0] addr_dw;
  logic        req_hit;

  assign bus_vld  = i_mmiobus[0];
  assign bus_cfg  = i_mmiobus[1];
  assign bus_rnw  = i_mmiobus[2];
  assign bus_dw   = i_mmiobus[3];
  assign bus_addr = i_mmiobus[4:27];
  assign bus_dat  = i_mmiobus[28:91];

  // Borrow out of the 25-bit subtraction flags addresses below the base.
  assign addr_off = {1'b0, bus_addr} - {1'b0, mmioaddr};
  assign addr_dw  = addr_off[23:1];
  assign req_hit  = bus_vld & ~bus_cfg & bus_dw & ~addr_off[24] & (addr_dw < 23'(n + 2));

  logic              req_vld_q, req_rnw_q;
  logic [IW-1:0]     req_idx_q;
  logic [63:0]       req_dat_q;
  logic [n-1:0]      inc_d1_q, inc_d2_q, inc_ok;
  logic [cwidth-1:0] cnt_q [n];
  logic [cwidth-1:0] cnt_d [n];
  logic [n-1:0]      ovf_q, ovf_d;
  logic              frz_q, cor_q;
  logic              rd_v1_q;
  logic [63:0]       rd_d1_q, rd_mux;
  logic              req_wr, req_rd, ctrl_wr, clr_all, ovf_wr;
  logic              unused_bits;

  assign unused_bits = ^{req_dat_q, addr_off[0]};

  assign req_wr  = req_vld_q & ~req_rnw_q;
  assign req_rd  = req_vld_q & req_rnw_q;
  assign ctrl_wr = req_wr & (req_idx_q == IDX_CTRL);
  assign clr_all = ctrl_wr & req_dat_q[0];
  assign ovf_wr  = req_wr & (req_idx_q == IDX_OVF);
  assign inc_ok  = inc_d2_q & {n{~frz_q}};

  // Per-counter priority: clear-all, write, clear-on-read, increment. Overflow set beats W1C.
  always_comb begin
    for (int k = 0; k < n; k++) begin
      cnt_d[k] = cnt_q[k];
      ovf_d[k] = ovf_q[k];
      if (ovf_wr && req_dat_q[k]) begin
        ovf_d[k] = 1'b0;
      end
      if (clr_all) begin
        cnt_d[k] = '0;
        ovf_d[k] = 1'b0;
      end else if (req_wr && (req_idx_q == IW'(k))) begin
        cnt_d[k] = req_dat_q[cwidth-1:0];
        ovf_d[k] = 1'b0;
      end else if (req_rd && cor_q && (req_idx_q == IW'(k))) begin
        cnt_d[k] = cwidth'(inc_ok[k]);
      end else if (inc_ok[k]) begin
        if (cnt_q[k] == CMAX) begin
          cnt_d[k] = sat ? CMAX : '0;
          ovf_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + cwidth'(1);
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (req_idx_q == IDX_CTRL) begin
      rd_mux[2:0] = {cor_q, frz_q, 1'b0};
    end else if (req_idx_q == IDX_OVF) begin
      rd_mux[n-1:0] = ovf_q;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (req_idx_q == IW'(k)) begin
          rd_mux[cwidth-1:0] = cnt_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_vld_q   <= 1'b0;
      req_rnw_q   <= 1'b0;
      req_idx_q   <= '0;
      req_dat_q   <= '0;
      inc_d1_q    <= '0;
      inc_d2_q    <= '0;
      ovf_q       <= '0;
      frz_q       <= 1'b0;
      cor_q       <= 1'b0;
      rd_v1_q     <= 1'b0;
      rd_d1_q     <= '0;
      o_mmio_rd_v <= 1'b0;
      o_mmio_rd_d <= '0;
      for (int k = 0; k < n; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      req_vld_q   <= req_hit;
      req_rnw_q   <= bus_rnw;
      req_idx_q   <= addr_dw[IW-1:0];
      req_dat_q   <= bus_dat;
      inc_d1_q    <= i_inc;
      inc_d2_q    <= inc_d1_q;
      ovf_q       <= ovf_d;
      if (ctrl_wr) begin
        frz_q <= req_dat_q[1];
        cor_q <= req_dat_q[2];
      end
      rd_v1_q     <= req_rd;
      rd_d1_q     <= req_rd ? rd_mux : '0;
      o_mmio_rd_v <= rd_v1_q;
      o_mmio_rd_d <= rd_d1_q;
      for (int k = 0; k < n; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_ktms_debug_cnt_bank.sv
// Bench: three banks (32-bit wrap, 4-bit wrap, 4-bit saturate) share one bus and strobe set,
// each checked every cycle against a per-bank integer reference of the counter rules.
module tb_ktms_debug_cnt_bank;

  localparam int          N    = 16;
  localparam int          NI   = 3;
  localparam logic [23:0] BASE = 24'h000100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_vld, b_cfg, b_rnw, b_dw;
  logic [23:0] b_addr;
  logic [63:0] b_dat;
  logic [0:91] bus;
  logic [N-1:0] inc;
  logic        rd_v [NI];
  logic [0:63] rd_d [NI];

  assign bus = {b_vld, b_cfg, b_rnw, b_dw, b_addr, b_dat};

  ktms_debug_cnt_bank #(.n(N), .cwidth(32), .sat(1'b0), .mmioaddr(BASE), .mmiobus_width(92)) dut0 (
    .clk(clk), .reset(rst_n), .i_mmiobus(bus), .i_inc(inc), .o_mmio_rd_v(rd_v[0]), .o_mmio_rd_d(rd_d[0]));
  ktms_debug_cnt_bank #(.n(N), .cwidth(4), .sat(1'b0), .mmioaddr(BASE), .mmiobus_width(92)) dut1 (
    .clk(clk), .reset(rst_n), .i_mmiobus(bus), .i_inc(inc), .o_mmio_rd_v(rd_v[1]), .o_mmio_rd_d(rd_d[1]));
  ktms_debug_cnt_bank #(.n(N), .cwidth(4), .sat(1'b1), .mmioaddr(BASE), .mmiobus_width(92)) dut2 (
    .clk(clk), .reset(rst_n), .i_mmiobus(bus), .i_inc(inc), .o_mmio_rd_v(rd_v[2]), .o_mmio_rd_d(rd_d[2]));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses0;

  // Reference state per bank.
  logic [63:0] mcnt [NI][N];
  logic [63:0] movf [NI];
  logic        mfrz [NI];
  logic        mcor [NI];
  logic        exp_v [NI];
  logic [63:0] exp_d [NI];
  logic        nxt_v [NI];
  logic [63:0] nxt_d [NI];
  logic [N-1:0] incq [$];
  logic        p_hit, p_rnw;
  logic [4:0]  p_idx;
  logic [63:0] p_dat;

  function automatic int wid(int i);
    return (i == 0) ? 32 : 4;
  endfunction

  function automatic logic [63:0] cmask(int i);
    return (wid(i) >= 64) ? '1 : ((64'd1 << wid(i)) - 64'd1);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(int i, logic [4:0] idx);
    if (idx < N)       return mcnt[i][idx];
    else if (idx == N) return {61'd0, mcor[i], mfrz[i], 1'b0};
    else               return movf[i];
  endfunction

  task automatic model_upd(input int i, input logic [N-1:0] inc2);
    logic clr, frz0, incr, wr_k, cor_k, set_k;
    logic [63:0] m;
    m    = cmask(i);
    frz0 = mfrz[i];
    clr  = p_hit && !p_rnw && (p_idx == N) && p_dat[0];
    for (int k = 0; k < N; k++) begin
      incr  = inc2[k] && !frz0;
      wr_k  = p_hit && !p_rnw && (p_idx == k);
      cor_k = p_hit && p_rnw && (p_idx == k) && mcor[i];
      set_k = 1'b0;
      if (clr)        mcnt[i][k] = 0;
      else if (wr_k)  mcnt[i][k] = p_dat & m;
      else if (cor_k) mcnt[i][k] = incr ? 64'd1 : 64'd0;
      else if (incr) begin
        if (mcnt[i][k] == m) begin
          set_k = 1'b1;
          mcnt[i][k] = (i == 2) ? m : 64'd0;
        end else begin
          mcnt[i][k] = mcnt[i][k] + 64'd1;
        end
      end
      if (clr || wr_k) movf[i][k] = 1'b0;
      else if (set_k)  movf[i][k] = 1'b1;
      else if (p_hit && !p_rnw && (p_idx == N + 1) && p_dat[k]) movf[i][k] = 1'b0;
    end
    if (p_hit && !p_rnw && (p_idx == N)) begin
      mfrz[i] = p_dat[1];
      mcor[i] = p_dat[2];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < N; k++) mcnt[i][k] = 0;
      movf[i] = 0; mfrz[i] = 0; mcor[i] = 0;
      exp_v[i] = 0; exp_d[i] = 0; nxt_v[i] = 0; nxt_d[i] = 0;
    end
    incq.delete();
    incq.push_back('0);
    incq.push_back('0);
    p_hit = 0; p_rnw = 0; p_idx = 0; p_dat = 0;
  endtask

  task automatic set_idle();
    b_vld = 0; b_cfg = 0; b_rnw = 0; b_dw = 0; b_addr = 0; b_dat = 0;
  endtask

  // One clock: advance the reference with the inputs sampled at this edge, then compare.
  task automatic tick();
    logic c_hit;
    logic [4:0] c_idx;
    logic [N-1:0] inc2;
    @(posedge clk);
    c_hit = b_vld && !b_cfg && b_dw && (b_addr >= BASE) && (b_addr < BASE + 24'(2 * (N + 2)));
    c_idx = 5'((b_addr - BASE) >> 1);
    inc2  = incq.pop_front();
    for (int i = 0; i < NI; i++) begin
      exp_v[i] = nxt_v[i];
      exp_d[i] = nxt_d[i];
      nxt_v[i] = p_hit && p_rnw;
      nxt_d[i] = nxt_v[i] ? model_rd(i, p_idx) : 64'd0;
      model_upd(i, inc2);
    end
    incq.push_back(inc);
    if (inc[0]) pulses0++;
    p_hit = c_hit; p_rnw = b_rnw; p_idx = c_idx; p_dat = b_dat;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("rd_v[%0d]", i), 64'(rd_v[i]), 64'(exp_v[i]));
      if (exp_v[i]) check_val($sformatf("rd_d[%0d]", i), rd_d[i], exp_d[i]);
    end
  endtask

  task automatic do_write(input int idx, input logic [63:0] dat);
    b_vld = 1; b_cfg = 0; b_rnw = 0; b_dw = 1; b_addr = BASE + 24'(2 * idx); b_dat = dat;
    tick();
    set_idle();
  endtask

  task automatic do_read(input int idx, output logic [63:0] d0, output logic [63:0] d1,
                         output logic [63:0] d2);
    int lat;
    b_vld = 1; b_cfg = 0; b_rnw = 1; b_dw = 1; b_addr = BASE + 24'(2 * idx); b_dat = 0;
    tick();
    set_idle();
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rd_v[0] && lat < 8);
    check_val("rd_latency", 64'(lat), 64'd2);
    d0 = rd_d[0]; d1 = rd_d[1]; d2 = rd_d[2];
  endtask

  initial begin
    logic [63:0] d0, d1, d2, a0, v0;
    logic [63:0] s_a, s_b, s_c;
    int r, idx;
    set_idle();
    inc = '0;
    rst_n = 0;
    model_reset();
    #12;
    for (int i = 0; i < NI; i++) begin
      check_val("reset_rd_v", 64'(rd_v[i]), 64'd0);
      check_val("reset_rd_d", rd_d[i], 64'd0);
    end
    @(negedge clk);
    rst_n = 1;

    do_read(0, d0, d1, d2);
    check_val("rst_cnt0", d0, 64'd0);
    do_read(N, d0, d1, d2);
    check_val("rst_ctrl", d0, 64'd0);

    inc = N'(1 << 3);
    repeat (5) tick();
    inc = '0;
    repeat (3) tick();
    do_read(3, d0, d1, d2);
    check_val("inc3_d0", d0, 64'd5);
    check_val("inc3_d2", d2, 64'd5);
    do_read(2, d0, d1, d2);
    check_val("idle2", d0, 64'd0);

    inc = N'(1 << 1);
    repeat (17) tick();
    inc = '0;
    repeat (3) tick();
    do_read(1, d0, d1, d2);
    check_val("wrap32", d0, 64'd17);
    check_val("wrap4", d1, 64'h1);
    check_val("sat4", d2, 64'hF);
    do_read(N + 1, d0, d1, d2);
    check_val("ovf32", d0, 64'h0);
    check_val("ovf_wrap4", d1, 64'h2);
    check_val("ovf_sat4", d2, 64'h2);
    do_write(N + 1, 64'h2);
    do_read(N + 1, d0, d1, d2);
    check_val("ovf_w1c_wrap", d1, 64'h0);
    check_val("ovf_w1c_sat", d2, 64'h0);

    do_write(0, 64'd0);
    do_write(N, 64'h4);
    pulses0 = 0;
    inc = N'(1);
    repeat (3) tick();
    do_read(0, s_a, d1, d2);
    repeat (10) tick();
    do_read(0, s_b, d1, d2);
    inc = '0;
    repeat (5) tick();
    do_read(0, s_c, d1, d2);
    check_val("cor_interval", s_b, 64'd13);
    check_val("cor_sum", s_a + s_b + s_c, 64'(pulses0));

    do_write(N, 64'h2);
    do_read(0, v0, d1, d2);
    inc = N'(1);
    repeat (4) tick();
    inc = '0;
    repeat (4) tick();
    do_read(0, d0, d1, d2);
    check_val("frz_hold", d0, v0);
    do_write(0, 64'h1234);
    do_read(0, d0, d1, d2);
    check_val("frz_wr32", d0, 64'h1234);
    check_val("frz_wr4", d1, 64'h4);
    do_read(N, d0, d1, d2);
    check_val("ctrl_frz", d0, 64'h2);
    do_write(N, 64'h0);

    for (int c = 0; c < 1500; c++) begin
      inc = N'($urandom & $urandom);
      set_idle();
      r = $urandom_range(0, 9);
      if (r < 4) begin
        idx = $urandom_range(0, N + 1);
        b_vld = 1; b_dw = 1; b_rnw = 1'($urandom_range(0, 1));
        b_addr = BASE + 24'(2 * idx + $urandom_range(0, 1));
        if (idx == N) b_dat = 64'($urandom_range(0, 7)) & (($urandom_range(0, 15) == 0) ? 64'd7 : 64'd6);
        else          b_dat = {$urandom, $urandom};
      end else if (r == 4) begin
        b_vld = 1; b_rnw = 1'($urandom_range(0, 1)); b_dat = {$urandom, $urandom};
        case ($urandom_range(0, 2))
          0: begin b_cfg = 1; b_dw = 1; b_addr = BASE; end
          1: begin b_dw = 0; b_addr = BASE + 24'd2; end
          default: begin
            b_dw = 1;
            b_addr = ($urandom_range(0, 1) == 1) ? BASE - 24'(1 + $urandom_range(0, 10))
                                                 : BASE + 24'(2 * (N + 2) + $urandom_range(0, 50));
          end
        endcase
      end
      tick();
    end
    inc = '0;
    set_idle();
    repeat (4) tick();

    do_write(N, 64'h0);
    do_write(N + 1, '1);
    for (int k = 0; k < N; k++) do_write(k, 64'((k % 15) + 1));
    do_write(5, '1);
    inc = N'(1 << 5);
    repeat (2) tick();
    inc = '0;
    repeat (3) tick();
    do_read(N + 1, d0, d1, d2);
    check_val("ovf_set32", d0, 64'h20);
    check_val("ovf_set4", d1, 64'h20);
    do_read(5, d0, d1, d2);
    check_val("sat_hold", d2, 64'hF);
    do_write(N, 64'h1);
    for (int k = 0; k < N + 2; k++) begin
      do_read(k, d0, d1, d2);
      check_val($sformatf("clr_idx%0d", k), d0 | d1 | d2, 64'd0);
    end

    b_vld = 1; b_rnw = 1; b_dw = 0; b_addr = BASE;
    tick();
    b_dw = 1; b_cfg = 1;
    tick();
    set_idle();
    repeat (4) begin
      tick();
      check_val("nohit_v", 64'(rd_v[0]), 64'd0);
    end

    do_write(3, 64'h77);
    b_vld = 1; b_rnw = 1; b_dw = 1; b_addr = BASE + 24'd6;
    tick();
    set_idle();
    #2;
    rst_n = 0;
    model_reset();
    repeat (4) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) check_val("rst_mid_v", 64'(rd_v[i]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1;
    do_read(3, d0, d1, d2);
    check_val("rst_mid_cnt", d0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
